// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO input conditioner: debounce FSM encoding and board-level defaults.
package gpio_pkg;

  localparam logic ST_STABLE   = 1'b0;
  localparam logic ST_COUNTING = 1'b1;

  localparam int GPIO_WIDTH_DEFAULT    = 8;
  localparam int GPIO_SYNC_DEFAULT     = 2;
  localparam int GPIO_DEBOUNCE_DEFAULT = 4;

endpackage

// File: rtl/gpio_input_conditioner_debounce_bit.sv
// One GPIO bit: synchronizer chain followed by a debounce FSM that registers the accepted
// level and a one-clock change pulse.
module debounce_bit
  import gpio_pkg::*;
#(
  parameter int   SYNC_STAGES     = GPIO_SYNC_DEFAULT,
  parameter int   DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEFAULT,
  parameter logic RESET_BIT       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  input  logic sample_en_i,
  output logic level_o,
  output logic change_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic                   state_q;
  logic [CW-1:0]          cnt_q;
  logic                   level_q;
  logic                   change_q;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Synchronizer shifts every clock, independent of the sample tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {SYNC_STAGES{RESET_BIT}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  // Debounce FSM: a new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_STABLE;
      cnt_q    <= '0;
      level_q  <= RESET_BIT;
      change_q <= 1'b0;
    end else begin
      change_q <= 1'b0;
      if (sample_en_i) begin
        case (state_q)
          ST_STABLE: begin
            if (sync_s != level_q) begin
              state_q <= ST_COUNTING;
              cnt_q   <= CW'(1);
            end else begin
              cnt_q   <= '0;
            end
          end
          ST_COUNTING: begin
            if (sync_s == level_q) begin
              state_q <= ST_STABLE;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_MAX) begin
              level_q  <= sync_s;
              change_q <= 1'b1;
              state_q  <= ST_STABLE;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
          end
        endcase
      end else begin
        cnt_q <= cnt_q;
      end
    end
  end

  assign level_o  = level_q;
  assign change_o = change_q;

endmodule

// File: rtl/gpio_input_conditioner.sv
// Synchronizes and debounces the external GPIO bus before it reaches the core.
// Optional sticky any-change flag is built when GPIO_CHANGE_FLAG_EN is defined.
module gpio_input_conditioner
  import gpio_pkg::*;
#(
  parameter int               WIDTH           = GPIO_WIDTH_DEFAULT,
  parameter int               SYNC_STAGES     = GPIO_SYNC_DEFAULT,
  parameter int               DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gpio_raw_i,
  input  logic             sample_en_i,
`ifdef GPIO_CHANGE_FLAG_EN
  input  logic             flag_clr_i,
  output logic             change_flag_o,
`endif
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] change_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_BIT      (RESET_VALUE[i])
    ) u_bit (
      .clk        (clk),
      .reset      (reset),
      .raw_i      (gpio_raw_i[i]),
      .sample_en_i(sample_en_i),
      .level_o    (gpio_o[i]),
      .change_o   (change_o[i])
    );
  end

`ifdef GPIO_CHANGE_FLAG_EN
  logic flag_q;

  // Sticky flag: a change pulse takes priority over a concurrent clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag_q <= 1'b0;
    end else if (|change_o) begin
      flag_q <= 1'b1;
    end else if (flag_clr_i) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_q;
    end
  end

  assign change_flag_o = flag_q;
`endif

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Self-checking bench: directed scenarios plus random traffic against a run-length reference model.
module tb_gpio_input_conditioner;

  localparam int W   = 8;
  localparam int S   = 2;
  localparam int D   = 4;
  localparam int LAT = S + D - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] gpio_raw = '0;
  logic         sample_en = 1'b1;
  logic [W-1:0] gpio_out;
  logic [W-1:0] change_out;
`ifdef GPIO_CHANGE_FLAG_EN
  logic         flag_clr = 1'b0;
  logic         change_flag;
  logic         flag_exp;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [W-1:0] hist [S];
  logic [W-1:0] lvl_exp;
  logic [W-1:0] chg_exp;
  int           run [W];

  always #5 clk = ~clk;

  gpio_input_conditioner #(
    .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .RESET_VALUE(8'h00)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .gpio_raw_i   (gpio_raw),
    .sample_en_i  (sample_en),
`ifdef GPIO_CHANGE_FLAG_EN
    .flag_clr_i   (flag_clr),
    .change_flag_o(change_flag),
`endif
    .gpio_o       (gpio_out),
    .change_o     (change_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < S; s++) hist[s] = '0;
    lvl_exp = '0;
    chg_exp = '0;
    for (int b = 0; b < W; b++) run[b] = 0;
`ifdef GPIO_CHANGE_FLAG_EN
    flag_exp = 1'b0;
`endif
  endtask

  // A bit flips once D consecutive enabled samples of the delayed raw value disagree with it.
  task automatic model_step();
    logic [W-1:0] seen;
    logic [W-1:0] prev_chg;
    prev_chg = chg_exp;
    seen = hist[S-1];
    for (int s = S - 1; s > 0; s--) hist[s] = hist[s-1];
    hist[0] = gpio_raw;
    chg_exp = '0;
    if (sample_en) begin
      for (int b = 0; b < W; b++) begin
        if (seen[b] != lvl_exp[b]) begin
          run[b] = run[b] + 1;
          if (run[b] == D) begin
            lvl_exp[b] = seen[b];
            chg_exp[b] = 1'b1;
            run[b] = 0;
          end
        end else begin
          run[b] = 0;
        end
      end
    end
`ifdef GPIO_CHANGE_FLAG_EN
    if (|prev_chg) flag_exp = 1'b1;
    else if (flag_clr) flag_exp = 1'b0;
`else
    if (|prev_chg) begin end
`endif
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_gpio"}, 32'(gpio_out), 32'(lvl_exp));
    chk({tag, "_chg"}, 32'(change_out), 32'(chg_exp));
`ifdef GPIO_CHANGE_FLAG_EN
    chk({tag, "_flag"}, 32'(change_flag), 32'(flag_exp));
`endif
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_outputs(tag);
  endtask

  // Ticks until (gpio_out & mask) == (val & mask); returns edges taken, or -1 on timeout.
  task automatic wait_val(input string tag, input logic [W-1:0] mask, input logic [W-1:0] val,
                          output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      tick(tag);
      if ((gpio_out & mask) == (val & mask)) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int total;
    model_reset();

    // T1: reset holds outputs low even with raw high
    gpio_raw = 8'hFF;
    #12;
    check_outputs("t1_rst");
    #13;
    reset = 1'b1;
    wait_val("t1", 8'hFF, 8'hFF, n);
    chk("t1_latency", 32'(n), 32'(LAT + 1));

    // T2: 2-clock glitch on bit0 never reaches output
    gpio_raw = 8'h00;
    wait_val("t2_settle", 8'hFF, 8'h00, n);
    repeat (3) tick("t2_idle");
    gpio_raw = 8'h01;
    repeat (2) tick("t2_hi");
    gpio_raw = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick("t2_lo");
      chk("t2_bit0", 32'(gpio_out[0]), 32'd0);
    end

    // T3: sample tick stalled for 10 clocks mid-count
    gpio_raw = 8'h08;
    total = 0;
    repeat (4) begin tick("t3_cnt"); total++; end
    sample_en = 1'b0;
    repeat (10) begin tick("t3_stall"); total++; end
    sample_en = 1'b1;
    wait_val("t3", 8'h08, 8'h08, n);
    total += n;
    chk("t3_latency", 32'(total), 32'(LAT + 1 + 10));
    chk("t3_pulse", 32'(change_out), 32'h08);
    tick("t3_after");
    chk("t3_pulse_end", 32'(change_out), 32'h00);

    // T4: several bits update together
    gpio_raw = 8'h00;
    wait_val("t4_settle", 8'hFF, 8'h00, n);
    repeat (3) tick("t4_idle");
    gpio_raw = 8'hA5;
    wait_val("t4", 8'hFF, 8'hA5, n);
    chk("t4_latency", 32'(n), 32'(LAT + 1));
    chk("t4_chg", 32'(change_out), 32'hA5);
    tick("t4_after");
    chk("t4_chg_end", 32'(change_out), 32'h00);

    // T5: reset while bit7 is counting restarts the full latency
    gpio_raw = 8'h00;
    wait_val("t5_settle", 8'hFF, 8'h00, n);
    repeat (3) tick("t5_idle");
    gpio_raw = 8'h80;
    repeat (4) tick("t5_cnt");
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs("t5_rst");
    @(negedge clk);
    reset = 1'b1;
    wait_val("t5", 8'h80, 8'h80, n);
    chk("t5_latency", 32'(n), 32'(LAT + 1));

`ifdef GPIO_CHANGE_FLAG_EN
    // T6: sticky flag, set wins over clear
    flag_clr = 1'b1;
    tick("t6_clr0");
    flag_clr = 1'b0;
    gpio_raw = 8'h82;
    wait_val("t6_set", 8'h02, 8'h02, n);
    repeat (3) tick("t6_hold");
    chk("t6_held", 32'(change_flag), 32'd1);
    gpio_raw = 8'h80;
    wait_val("t6_chg2", 8'h02, 8'h00, n);
    flag_clr = 1'b1;
    tick("t6_conc");
    chk("t6_set_wins", 32'(change_flag), 32'd1);
    tick("t6_lone");
    chk("t6_cleared", 32'(change_flag), 32'd0);
    flag_clr = 1'b0;
`endif

    // Random traffic: sparse bit flips, random sample ticks
    for (int i = 0; i < 600; i++) begin
      gpio_raw = gpio_raw ^ W'($urandom & $urandom & $urandom);
      sample_en = ($urandom_range(0, 4) != 0);
`ifdef GPIO_CHANGE_FLAG_EN
      flag_clr = ($urandom_range(0, 3) == 0);
`endif
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
